// File: rtl/elevator_plant_model_pkg.sv
// rtl/elevator_plant_model_pkg.sv - command, sensor and fault encodings for the elevator plant
package elevator_plant_model_pkg;

  typedef enum logic [1:0] {
    ENGINE_STOP    = 2'b00,
    ENGINE_UP      = 2'b01,
    ENGINE_DOWN    = 2'b10,
    ENGINE_ILLEGAL = 2'b11
  } engine_cmd_e;

  typedef enum logic [1:0] {
    DOOR_HOLD    = 2'b00,
    DOOR_OPEN    = 2'b01,
    DOOR_CLOSE   = 2'b10,
    DOOR_ILLEGAL = 2'b11
  } door_cmd_e;

  localparam logic [1:0] SENSOR_DOOR_CLOSED = 2'b10;
  localparam logic [1:0] SENSOR_DOOR_OPEN   = 2'b01;
  localparam logic [1:0] SENSOR_DOOR_TRAVEL = 2'b00;

  // Bit positions inside fault_code
  localparam int FAULT_MOVE_DOOR   = 0;
  localparam int FAULT_DOOR_PARKED = 1;
  localparam int FAULT_OVERTRAVEL  = 2;
  localparam int FAULT_ILLEGAL     = 3;

endpackage

// File: rtl/elevator_plant_model_door_actuator.sv
// rtl/elevator_plant_model_door_actuator.sv - door stroke counter with limit sensor decode
module elevator_door_actuator
  import elevator_plant_model_pkg::*;
#(
  parameter int DELAY_DOOR = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] door_cmd,
  input  logic       open_en,
  output logic       door_closed,
  output logic [1:0] sensor_door
);

  localparam int DW = $clog2(DELAY_DOOR + 1);
  localparam logic [DW-1:0] DOOR_FULL = DW'(DELAY_DOOR);

  logic [DW-1:0] door_q, door_d;

  // Next door position: open only when the parent allows it, close always, both saturating
  always_comb begin
    door_d = door_q;
    if (door_cmd == DOOR_OPEN && open_en && door_q != DOOR_FULL) begin
      door_d = door_q + DW'(1);
    end else if (door_cmd == DOOR_CLOSE && door_q != '0) begin
      door_d = door_q - DW'(1);
    end
  end

  // Door position register, closed after reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      door_q <= '0;
    end else begin
      door_q <= door_d;
    end
  end

  assign door_closed = (door_q == '0);
  assign sensor_door = door_closed           ? SENSOR_DOOR_CLOSED :
                       (door_q == DOOR_FULL) ? SENSOR_DOOR_OPEN   : SENSOR_DOOR_TRAVEL;

endmodule

// File: rtl/elevator_plant_model.sv
// rtl/elevator_plant_model.sv - elevator car/shaft plant: position, limits, door and sticky faults
module elevator_plant_model
  import elevator_plant_model_pkg::*;
#(
  parameter int FLOORS       = 8,
  parameter int DELAY_ENGINE = 10,
  parameter int DELAY_DOOR   = 10,
  parameter int START_FLOOR  = 0,
  localparam int FLOOR_W     = $clog2(FLOORS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         engine,
  input  logic [1:0]         door,
  output logic [1:0]         sensor_door,
  output logic               sensor_up,
  output logic               sensor_down,
  output logic [FLOOR_W-1:0] floor,
  output logic               at_floor,
  output logic               fault,
  output logic [3:0]         fault_code
);

  localparam int SUB_W = $clog2(DELAY_ENGINE);
  localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(DELAY_ENGINE - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_TOP = FLOOR_W'(FLOORS - 1);

  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [3:0]         fault_q, fault_d;
  logic               door_closed;
  logic               door_open_en;
  logic               at_top, at_bottom;
  logic               move_cmd;

  assign at_floor     = (sub_q == '0);
  assign at_top       = at_floor && (floor_q == FLOOR_TOP);
  assign at_bottom    = at_floor && (floor_q == '0);
  assign move_cmd     = (engine == ENGINE_UP) || (engine == ENGINE_DOWN);
  // The door may only open while parked at a floor with the engine stopped
  assign door_open_en = at_floor && (engine == ENGINE_STOP);

  elevator_door_actuator #(
    .DELAY_DOOR (DELAY_DOOR)
  ) u_door (
    .clk         (clk),
    .reset       (reset),
    .door_cmd    (door),
    .open_en     (door_open_en),
    .door_closed (door_closed),
    .sensor_door (sensor_door)
  );

  // Car motion and fault accumulation; the engine is judged before the door
  always_comb begin
    floor_d = floor_q;
    sub_d   = sub_q;
    fault_d = fault_q;
    if (engine == ENGINE_ILLEGAL || door == DOOR_ILLEGAL) begin
      fault_d[FAULT_ILLEGAL] = 1'b1;
    end
    if (move_cmd && !door_closed) begin
      fault_d[FAULT_MOVE_DOOR] = 1'b1;
    end else if (engine == ENGINE_UP) begin
      if (at_top) begin
        fault_d[FAULT_OVERTRAVEL] = 1'b1;
      end else if (sub_q == SUB_LAST) begin
        floor_d = floor_q + FLOOR_W'(1);
        sub_d   = '0;
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end else if (engine == ENGINE_DOWN) begin
      if (at_bottom) begin
        fault_d[FAULT_OVERTRAVEL] = 1'b1;
      end else if (sub_q == '0) begin
        floor_d = floor_q - FLOOR_W'(1);
        sub_d   = SUB_LAST;
      end else begin
        sub_d = sub_q - SUB_W'(1);
      end
    end
    if (door == DOOR_OPEN && !door_open_en) begin
      fault_d[FAULT_DOOR_PARKED] = 1'b1;
    end
  end

  // Position and fault registers; reset wins over any command, even mid-travel
  always_ff @(posedge clk) begin
    if (!reset) begin
      floor_q <= FLOOR_W'(START_FLOOR);
      sub_q   <= '0;
      fault_q <= '0;
    end else begin
      floor_q <= floor_d;
      sub_q   <= sub_d;
      fault_q <= fault_d;
    end
  end

  assign floor       = floor_q;
  assign sensor_up   = at_top;
  assign sensor_down = at_bottom;
  assign fault_code  = fault_q;
  assign fault       = |fault_q;

endmodule

// File: tb/tb_elevator_plant_model.sv
// tb/tb_elevator_plant_model.sv - directed table-driven bench for elevator_plant_model
module tb_elevator_plant_model;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] engine;
  logic [1:0] door;
  logic [1:0] sensor_door;
  logic       sensor_up;
  logic       sensor_down;
  logic [2:0] floor;
  logic       at_floor;
  logic       fault;
  logic [3:0] fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [1:0] eng;
    logic [1:0] dr;
    int         n;
    logic [2:0] e_floor;
    logic       e_at;
    logic       e_up;
    logic       e_dn;
    logic [1:0] e_sd;
    logic [3:0] e_fc;
  } vec_t;

  vec_t vecs[$];

  elevator_plant_model #(
    .FLOORS       (8),
    .DELAY_ENGINE (10),
    .DELAY_DOOR   (10),
    .START_FLOOR  (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .engine      (engine),
    .door        (door),
    .sensor_door (sensor_door),
    .sensor_up   (sensor_up),
    .sensor_down (sensor_down),
    .floor       (floor),
    .at_floor    (at_floor),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic rst_n, logic [1:0] eng, logic [1:0] dr, int n,
                              logic [2:0] f, logic at, logic up, logic dn, logic [1:0] sd, logic [3:0] fc);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.eng = eng; v.dr = dr; v.n = n;
    v.e_floor = f; v.e_at = at; v.e_up = up; v.e_dn = dn; v.e_sd = sd; v.e_fc = fc;
    return v;
  endfunction

  // Compares every output at once; fault must always equal OR of the expected code
  task automatic check(string name, logic [2:0] f, logic at, logic up, logic dn, logic [1:0] sd, logic [3:0] fc);
    logic [12:0] act, exp;
    act = {floor, at_floor, sensor_up, sensor_down, sensor_door, fault_code, fault};
    exp = {f, at, up, dn, sd, fc, |fc};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got floor=%0d at=%b up=%b dn=%b sd=%b fc=%b flt=%b, want floor=%0d at=%b up=%b dn=%b sd=%b fc=%b flt=%b",
               name, floor, at_floor, sensor_up, sensor_down, sensor_door, fault_code, fault,
               f, at, up, dn, sd, fc, |fc);
    end
  endtask

  task automatic step(logic rst_n, logic [1:0] eng, logic [1:0] dr, int n);
    reset  = rst_n;
    engine = eng;
    door   = dr;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    engine = 2'b00;
    door   = 2'b00;

    //          name              rst eng    door   n   fl at up dn sd     fc
    vecs.push_back(mk("reset",        0, 2'b00, 2'b00, 1,  0, 1, 0, 1, 2'b10, 4'b0000));
    vecs.push_back(mk("up_one_floor", 1, 2'b01, 2'b00, 10, 1, 1, 0, 0, 2'b10, 4'b0000));
    vecs.push_back(mk("up_to_top",    1, 2'b01, 2'b00, 60, 7, 1, 1, 0, 2'b10, 4'b0000));
    vecs.push_back(mk("overtravel_up",1, 2'b01, 2'b00, 1,  7, 1, 1, 0, 2'b10, 4'b0100));
    vecs.push_back(mk("reset_clears", 0, 2'b00, 2'b00, 1,  0, 1, 0, 1, 2'b10, 4'b0000));
    vecs.push_back(mk("up_two",       1, 2'b01, 2'b00, 20, 2, 1, 0, 0, 2'b10, 4'b0000));
    vecs.push_back(mk("mid_floor",    1, 2'b01, 2'b00, 4,  2, 0, 0, 0, 2'b10, 4'b0000));
    vecs.push_back(mk("open_unparked",1, 2'b00, 2'b01, 1,  2, 0, 0, 0, 2'b10, 4'b0010));
    vecs.push_back(mk("reverse_back", 1, 2'b10, 2'b00, 4,  2, 1, 0, 0, 2'b10, 4'b0010));
    vecs.push_back(mk("reset2",       0, 2'b00, 2'b00, 1,  0, 1, 0, 1, 2'b10, 4'b0000));
    vecs.push_back(mk("illegal_eng",  1, 2'b11, 2'b00, 1,  0, 1, 0, 1, 2'b10, 4'b1000));
    vecs.push_back(mk("open_partial", 1, 2'b00, 2'b01, 5,  0, 1, 0, 1, 2'b00, 4'b1000));
    vecs.push_back(mk("reset_door",   0, 2'b00, 2'b01, 1,  0, 1, 0, 1, 2'b10, 4'b0000));
    vecs.push_back(mk("overtravel_dn",1, 2'b10, 2'b00, 1,  0, 1, 0, 1, 2'b10, 4'b0100));
    vecs.push_back(mk("reset3",       0, 2'b00, 2'b00, 1,  0, 1, 0, 1, 2'b10, 4'b0000));
    vecs.push_back(mk("up_three",     1, 2'b01, 2'b00, 30, 3, 1, 0, 0, 2'b10, 4'b0000));
    vecs.push_back(mk("down_one_edge",1, 2'b10, 2'b00, 1,  2, 0, 0, 0, 2'b10, 4'b0000));
    vecs.push_back(mk("reverse_up",   1, 2'b01, 2'b00, 1,  3, 1, 0, 0, 2'b10, 4'b0000));
    vecs.push_back(mk("stop_holds",   1, 2'b00, 2'b00, 7,  3, 1, 0, 0, 2'b10, 4'b0000));
    vecs.push_back(mk("door_full",    1, 2'b00, 2'b01, 10, 3, 1, 0, 0, 2'b01, 4'b0000));
    vecs.push_back(mk("door_sat_open",1, 2'b00, 2'b01, 3,  3, 1, 0, 0, 2'b01, 4'b0000));
    vecs.push_back(mk("close_part",   1, 2'b00, 2'b10, 3,  3, 1, 0, 0, 2'b00, 4'b0000));
    vecs.push_back(mk("close_full",   1, 2'b00, 2'b10, 7,  3, 1, 0, 0, 2'b10, 4'b0000));
    vecs.push_back(mk("close_sat",    1, 2'b00, 2'b10, 1,  3, 1, 0, 0, 2'b10, 4'b0000));
    vecs.push_back(mk("illegal_door", 1, 2'b00, 2'b11, 1,  3, 1, 0, 0, 2'b10, 4'b1000));
    vecs.push_back(mk("move_after_f", 1, 2'b10, 2'b00, 10, 2, 1, 0, 0, 2'b10, 4'b1000));
    vecs.push_back(mk("move_open_dr", 1, 2'b01, 2'b01, 1,  2, 0, 0, 0, 2'b10, 4'b1010));
    vecs.push_back(mk("partial_up",   1, 2'b01, 2'b00, 5,  2, 0, 0, 0, 2'b10, 4'b1010));
    vecs.push_back(mk("reset_midtrav",0, 2'b01, 2'b00, 1,  0, 1, 0, 1, 2'b10, 4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].eng, vecs[i].dr, vecs[i].n);
      check(vecs[i].name, vecs[i].e_floor, vecs[i].e_at, vecs[i].e_up, vecs[i].e_dn, vecs[i].e_sd, vecs[i].e_fc);
    end

    // Door stroke at floor 1, checked on every edge, then a move request with the door open
    step(1'b0, 2'b00, 2'b00, 1);
    step(1'b1, 2'b01, 2'b00, 10);
    check("seq_at_floor1", 3'd1, 1'b1, 1'b0, 1'b0, 2'b10, 4'b0000);
    for (int e = 1; e <= 10; e++) begin
      step(1'b1, 2'b00, 2'b01, 1);
      if (e < 10) check($sformatf("seq_door_edge%0d", e), 3'd1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
      else        check("seq_door_open", 3'd1, 1'b1, 1'b0, 1'b0, 2'b01, 4'b0000);
    end
    step(1'b1, 2'b01, 2'b00, 1);
    check("seq_move_door_open", 3'd1, 1'b1, 1'b0, 1'b0, 2'b01, 4'b0001);
    step(1'b1, 2'b10, 2'b10, 1);
    check("seq_down_closing", 3'd1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
